dmem_address_gen: RTL and testbench



---
 rtl/dmem_address_gen.sv | 51 +++++
 tb/tb_dmem_address_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_address_gen.sv
// Diagonal tiled DMEM read-address generator for the binary-MLP datapath.
// Walks 8 start blocks x 8 sub-blocks x 2 words, one address per enabled clock.
module dmem_address_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [6:0] dmem_addr,
  output logic [2:0] nxt_start_block,
  output logic [2:0] nxt_sub_block
);

  logic [2:0] s_q, s_d;
  logic [2:0] b_q, b_d;
  logic       w_q, w_d;
  logic [6:0] addr_q, addr_d;
  logic [2:0] diag_d;

  always_comb begin
    w_d = ~w_q;
    b_d = b_q;
    s_d = s_q;
    if (w_q) begin
      b_d = b_q + 3'd1;
      if (b_q == 3'd7) begin
        s_d = s_q + 3'd1;
      end
    end
    diag_d = s_d + b_d;
    addr_d = {diag_d, b_d, w_d};
  end

  // Address is registered alongside state so en never reaches dmem_addr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= 3'd0;
      b_q    <= 3'd0;
      w_q    <= 1'b0;
      addr_q <= 7'd0;
    end else if (en) begin
      s_q    <= s_d;
      b_q    <= b_d;
      w_q    <= w_d;
      addr_q <= addr_d;
    end
  end

  assign dmem_addr       = addr_q;
  assign nxt_start_block = s_d;
  assign nxt_sub_block   = b_d;

endmodule

// File: tb/tb_dmem_address_gen.sv
// Directed self-checking bench for dmem_address_gen.
// Each scenario task drives its own stimulus and checks inline.
module tb_dmem_address_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [6:0] dmem_addr;
  logic [2:0] nxt_start_block;
  logic [2:0] nxt_sub_block;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_address_gen dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .dmem_addr       (dmem_addr),
    .nxt_start_block (nxt_start_block),
    .nxt_sub_block   (nxt_sub_block)
  );

  always #5 clk = ~clk;

  // Address after n enabled edges from reset.
  function automatic logic [6:0] exp_addr(input int n);
    logic [6:0] k;
    logic [2:0] s, b, d;
    k = 7'(n % 128);
    s = k[6:4];
    b = k[3:1];
    d = s + b;
    return {d, b, k[0]};
  endfunction

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    en  = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dmem_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_addr got %0d want 0", dmem_addr);
    end
    n_checks++;
    if (nxt_start_block !== 3'd0 || nxt_sub_block !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_nxt got %0d/%0d want 0/0",
               nxt_start_block, nxt_sub_block);
    end
    en  = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_first_blocks();
    logic [6:0] tbl [0:17];
    tbl = '{7'd1, 7'd18, 7'd19, 7'd36, 7'd37, 7'd54, 7'd55,
            7'd72, 7'd73, 7'd90, 7'd91, 7'd108, 7'd109,
            7'd126, 7'd127, 7'd16, 7'd17, 7'd34};
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b1);
      n_checks++;
      if (dmem_addr !== tbl[i]) begin
        n_fail++;
        $display("FAIL first_edge%0d got %0d want %0d",
                 i + 1, dmem_addr, tbl[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (nxt_start_block !== 3'd0 || nxt_sub_block !== 3'd1) begin
          n_fail++;
          $display("FAIL nxt_at_1 got %0d/%0d want 0/1",
                   nxt_start_block, nxt_sub_block);
        end
      end
      if (i == 14) begin
        n_checks++;
        if (nxt_start_block !== 3'd1 || nxt_sub_block !== 3'd0) begin
          n_fail++;
          $display("FAIL nxt_at_127 got %0d/%0d want 1/0",
                   nxt_start_block, nxt_sub_block);
        end
      end
    end
  endtask

  task automatic test_full_wrap();
    int errs;
    do_reset();
    errs = 0;
    for (int n = 1; n <= 256; n++) begin
      step(1'b1);
      if (dmem_addr !== exp_addr(n)) begin
        errs++;
        if (errs < 4)
          $display("FAIL wrap_edge%0d got %0d want %0d",
                   n, dmem_addr, exp_addr(n));
      end
      if (n == 127) begin
        n_checks++;
        if (dmem_addr !== 7'd111 || nxt_start_block !== 3'd0
            || nxt_sub_block !== 3'd0) begin
          n_fail++;
          $display("FAIL edge127 got %0d %0d/%0d want 111 0/0",
                   dmem_addr, nxt_start_block, nxt_sub_block);
        end
      end
      if (n == 128) begin
        n_checks++;
        if (dmem_addr !== 7'd0) begin
          n_fail++;
          $display("FAIL edge128 got %0d want 0", dmem_addr);
        end
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL two_pass_seq got %0d bad edges want 0", errs);
    end
  endtask

  task automatic test_en_gating();
    do_reset();
    repeat (4) step(1'b1);
    n_checks++;
    if (dmem_addr !== 7'd36) begin
      n_fail++;
      $display("FAIL gate_pre got %0d want 36", dmem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      n_checks++;
      if (dmem_addr !== 7'd36 || nxt_start_block !== 3'd0
          || nxt_sub_block !== 3'd2) begin
        n_fail++;
        $display("FAIL gate_hold%0d got %0d %0d/%0d want 36 0/2",
                 i, dmem_addr, nxt_start_block, nxt_sub_block);
      end
    end
    step(1'b1);
    n_checks++;
    if (dmem_addr !== 7'd37) begin
      n_fail++;
      $display("FAIL gate_resume got %0d want 37", dmem_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (18) step(1'b1);
    n_checks++;
    if (dmem_addr !== 7'd34) begin
      n_fail++;
      $display("FAIL arst_pre got %0d want 34", dmem_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (dmem_addr !== 7'd0 || nxt_start_block !== 3'd0
        || nxt_sub_block !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_imm got %0d %0d/%0d want 0 0/0",
               dmem_addr, nxt_start_block, nxt_sub_block);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_checks++;
      if (dmem_addr !== 7'd0) begin
        n_fail++;
        $display("FAIL arst_hold%0d got %0d want 0", i, dmem_addr);
      end
    end
    en  = 1'b0;
    rst = 1'b1;
    step(1'b1);
    n_checks++;
    if (dmem_addr !== 7'd1) begin
      n_fail++;
      $display("FAIL arst_release got %0d want 1", dmem_addr);
    end
  endtask

  task automatic test_pulses();
    logic [6:0] tbl [0:2];
    tbl = '{7'd1, 7'd18, 7'd19};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_checks++;
      if (dmem_addr !== tbl[i]) begin
        n_fail++;
        $display("FAIL pulse%0d got %0d want %0d", i, dmem_addr, tbl[i]);
      end
      repeat (2) step(1'b0);
      n_checks++;
      if (dmem_addr !== tbl[i]) begin
        n_fail++;
        $display("FAIL pulse_hold%0d got %0d want %0d",
                 i, dmem_addr, tbl[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_blocks();
    test_full_wrap();
    test_en_gating();
    test_async_reset();
    test_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
